// File: rtl/multi_pit.sv
// multi_pit: NUM_CH up-counting interval timers sharing one prescaler, with fire pulses, sticky pending and masked irq
module multi_pit #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int PRE_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic              cfg_enable,
  input  logic              cfg_repeat,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic [NUM_CH-1:0] irq_clear,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_count,
  output logic              rd_active,
  output logic [NUM_CH-1:0] fire,
  output logic [NUM_CH-1:0] pending,
  output logic              irq
);
  logic [PRE_W-1:0]  pc;
  logic              tick;
  logic              rd_ok;
  logic [WIDTH-1:0]  count  [NUM_CH];
  logic [WIDTH-1:0]  period [NUM_CH];
  logic [NUM_CH-1:0] enable, rpt, wr, run, expire, pending_next;
  // >= rather than == so a lowered prescale takes effect immediately
  assign tick  = pc >= prescale;
  assign rd_ok = 32'(rd_ch) < NUM_CH;
  assign rd_count  = rd_ok ? count[rd_ch] : '0;
  assign rd_active = rd_ok ? enable[rd_ch] : 1'b0;
  always_comb begin
    wr     = '0;
    run    = '0;
    expire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i]     = cfg_we && (cfg_ch == CH_W'(i));
      run[i]    = tick && enable[i] && (period[i] != '0) && !wr[i];
      expire[i] = run[i] && (count[i] == period[i] - WIDTH'(1));
    end
    pending_next = expire | (pending & ~irq_clear);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      fire    <= '0;
      pending <= '0;
      irq     <= 1'b0;
      enable  <= '0;
      rpt     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        period[i] <= '0;
      end
    end else begin
      pc      <= tick ? '0 : pc + PRE_W'(1);
      fire    <= expire;
      pending <= pending_next;
      irq     <= |(pending_next & irq_mask);
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr[i]) begin
          period[i] <= cfg_period;
          enable[i] <= cfg_enable;
          rpt[i]    <= cfg_repeat;
          count[i]  <= '0;
        end else if (run[i]) begin
          count[i] <= expire[i] ? '0 : count[i] + WIDTH'(1);
          if (expire[i] && !rpt[i]) enable[i] <= 1'b0;
        end
      end
    end
  end
endmodule
